// File: rtl/io_pkg.sv
// Shared register offsets, STATUS bit positions and TX state encoding for the memory-mapped UART.
package io_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] OFF_TXDATA = 16'd0;
    localparam logic [ADDR_W-1:0] OFF_STATUS = 16'd1;
    localparam logic [ADDR_W-1:0] OFF_DIV    = 16'd2;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_FULL = 1;
    localparam int unsigned ST_OVF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_io_if.sv
// CPU-side bus between a bus master and the memory-mapped UART.
interface uart_io_if;
    import io_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic              wren_n;
    logic              oen_n;
    logic [DATA_W-1:0] data_in;
    logic              sel;

    modport master (
        output address, data_out, wren_n, oen_n,
        input  data_in, sel
    );

    modport slave (
        input  address, data_out, wren_n, oen_n,
        output data_in, sel
    );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO; a push while full is dropped and a pop while empty is ignored.
module io_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata_c,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata_c = mem[rd_ptr];

    // Count never wraps: only accepted pushes/pops move it.
    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, STATUS and bit-period divisor registers.
// Define UART_IO_DIV_REG_EN to make the divisor writable at BASE+2.
module uart_io
    import io_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'hFF00,
    parameter logic [15:0] CLK_DIV    = 16'd434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_io_if.slave  bus,
    output logic      tx
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef UART_IO_DIV_REG_EN
    localparam logic [ADDR_W-1:0] LAST_OFF = OFF_DIV;
`else
    localparam logic [ADDR_W-1:0] LAST_OFF = OFF_STATUS;
`endif

    logic [ADDR_W-1:0] off_c;
    logic              sel_c;
    logic              wren_q;
    logic              wr_c;
    logic              push_c;
    logic              pop_c;
    logic              overflow_q;
    logic              busy_c;
    logic [DATA_W-1:0] rdata_c;
    logic [DATA_W-1:0] div_q;
    logic [15:0]       period_m1_c;

    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [CNT_W-1:0]  unused_fifo_count;

    tx_state_e         state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    // Addresses below BASE wrap to large offsets, so one compare decodes the window.
    assign off_c   = bus.address - BASE;
    assign sel_c   = (off_c <= LAST_OFF);
    assign bus.sel = sel_c;

    assign wr_c   = !bus.wren_n && wren_q && sel_c;
    assign push_c = wr_c && (off_c == OFF_TXDATA);
    assign busy_c = (state_q != IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_q <= 1'b1;
        end else begin
            wren_q <= bus.wren_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (push_c && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (wr_c && (off_c == OFF_STATUS) && bus.data_out[ST_OVF]) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef UART_IO_DIV_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= CLK_DIV;
        end else if (wr_c && (off_c == OFF_DIV)) begin
            div_q <= bus.data_out;
        end
    end
`else
    logic [7:0] unused_data_hi;
    assign unused_data_hi = bus.data_out[15:8];
    assign div_q          = CLK_DIV;
`endif

    assign period_m1_c = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

    // Reads are suppressed while a write strobe is also active.
    always_comb begin
        rdata_c = '0;
        if (sel_c && !bus.oen_n && bus.wren_n) begin
            case (off_c)
                OFF_STATUS: begin
                    rdata_c[ST_BUSY] = busy_c;
                    rdata_c[ST_FULL] = fifo_full;
                    rdata_c[ST_OVF]  = overflow_q;
                end
`ifdef UART_IO_DIV_REG_EN
                OFF_DIV:    rdata_c = div_q;
`endif
                default:    rdata_c = '0;
            endcase
        end
    end
    assign bus.data_in = rdata_c;

    io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wdata   (bus.data_out[7:0]),
        .pop     (pop_c),
        .rdata_c (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Bit timer reloads from the divisor only at bit boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = period_m1_c;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d   = period_m1_c;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d = period_m1_c;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = period_m1_c;
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io: decode/read table plus multi-cycle TX, FIFO, reset and divisor sequences.
module tb_uart_io;

    localparam int unsigned BIT = 4;

    logic clk;
    logic rst_n;
    logic tx;
    int   cyc;
    int   checks;
    int   errors;
    logic mon_en;
    logic [7:0] mon_byte;
    logic [7:0] rx_q[$];

    uart_io_if bus();

    uart_io #(
        .BASE       (16'hFF00),
        .CLK_DIV    (16'd4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx)
    );

    typedef struct {
        logic [15:0] addr;
        logic        oen_n;
        logic        wren_n;
        logic [15:0] wdata;
        logic        exp_sel;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Serial receiver: samples mid-bit assuming a BIT-cycle period.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx == 1'b0) begin
                mon_byte = 8'h00;
                repeat (BIT + BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    mon_byte[i] = tx;
                    if (i < 7) repeat (BIT) @(negedge clk);
                end
                repeat (BIT) @(negedge clk);
                if (tx == 1'b1) rx_q.push_back(mon_byte);
                else rx_q.push_back(8'hEE);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.address  = a;
        bus.data_out = d;
        bus.wren_n   = 1'b0;
        @(negedge clk);
        bus.wren_n   = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic s);
        @(negedge clk);
        bus.address = a;
        bus.oen_n   = 1'b0;
        #1;
        d = bus.data_in;
        s = bus.sel;
        bus.oen_n = 1'b1;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        logic        s;
        bus_read(a, d, s);
        check(name, 32'(d), 32'(exp));
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [15:0] d;
        logic        s;
        int          n;
        n = 0;
        d = 16'hFFFF;
        while (d != 16'h0000 && n < budget) begin
            bus_read(16'hFF01, d, s);
            n++;
        end
        check(name, 32'(d), 32'h0);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_start(input string name, output int s);
        int n;
        n = 0;
        @(negedge clk);
        while (tx != 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(tx), 32'h0);
        s = cyc;
    endtask

    initial begin
        int   s;
        int   highs;
        logic [15:0] d;
        logic        sl;
        logic [7:0]  exp_bytes[6];
        logic        exp_tx;

        checks = 0;
        errors = 0;
        cyc    = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        bus.address  = 16'hFF01;
        bus.data_out = 16'h0000;
        bus.wren_n   = 1'b1;
        bus.oen_n    = 1'b0;

        vecs[0] = '{16'hFF00, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[1] = '{16'hFF01, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
`ifdef UART_IO_DIV_REG_EN
        vecs[2] = '{16'hFF02, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0004};
`else
        vecs[2] = '{16'hFF02, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
`endif
        vecs[3] = '{16'hFF01, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[4] = '{16'hFE00, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[5] = '{16'hFF03, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[6] = '{16'hFEFF, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[7] = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[8] = '{16'hFF01, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};

        // Reset: combinational decode still live, line idle.
        #12;
        check("reset_tx", 32'(tx), 32'h1);
        check("reset_sel", 32'(bus.sel), 32'h1);
        check("reset_status", 32'(bus.data_in), 32'h0);
        bus.oen_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Decode and read-path table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.address  = vecs[i].addr;
            bus.oen_n    = vecs[i].oen_n;
            bus.wren_n   = vecs[i].wren_n;
            bus.data_out = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_data", i), 32'(bus.data_in), 32'(vecs[i].exp_data));
        end
        @(negedge clk);
        bus.wren_n = 1'b1;
        bus.oen_n  = 1'b1;

        // Single frame of 0x55, cycle-exact.
        mon_en = 1'b1;
        bus_write(16'hFF00, 16'h0055);
        check("latency_n1_idle", 32'(tx), 32'h1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k < 4) exp_tx = 1'b0;
            else if (k < 36) exp_tx = ((8'h55 >> ((k - 4) / 4)) & 8'h01) != 8'h00;
            else exp_tx = 1'b1;
            check($sformatf("frame55_c%0d", k), 32'(tx), 32'(exp_tx));
        end
        read_check("frame55_busy_clear", 16'hFF01, 16'h0000);

        // Overflow: four queue behind an active frame, fifth dropped.
        bus_write(16'hFF00, 16'h00AA);
        for (int b = 1; b <= 5; b++) bus_write(16'hFF00, 16'(b));
        read_check("ovf_status", 16'hFF01, 16'h0007);
        bus_write(16'hFF01, 16'h0004);
        read_check("ovf_cleared", 16'hFF01, 16'h0003);
        wait_idle("ovf_drain", 400);
        repeat (2) @(negedge clk);
        exp_bytes = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};
        check("rx_count", 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) check($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
        end

        // Held write strobe queues one byte.
        rx_q.delete();
        @(negedge clk);
        bus.address  = 16'hFF00;
        bus.data_out = 16'h003C;
        bus.wren_n   = 1'b0;
        repeat (3) @(negedge clk);
        bus.wren_n = 1'b1;
        wait_idle("held_drain", 200);
        repeat (2) @(negedge clk);
        check("held_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("held_rx_byte", 32'(rx_q[0]), 32'h3C);
        mon_en = 1'b0;

        // Writes outside the window do nothing.
        bus_write(16'hFE00, 16'h00AA);
        bus_write(16'hFF03, 16'h00AA);
        read_check("unmapped_write", 16'hFF01, 16'h0000);

`ifdef UART_IO_DIV_REG_EN
        // Divisor change mid-bit applies from the next boundary.
        bus_write(16'hFF02, 16'd8);
        read_check("div_read8", 16'hFF02, 16'h0008);
        bus_write(16'hFF00, 16'h000F);
        wait_start("div_start", s);
        bus_write(16'hFF02, 16'd2);
        wait_to(s + 7);
        check("div_old_bit_end", 32'(tx), 32'h0);
        wait_to(s + 8);
        check("div_bit0", 32'(tx), 32'h1);
        wait_to(s + 15);
        check("div_bit3", 32'(tx), 32'h1);
        wait_to(s + 16);
        check("div_bit4", 32'(tx), 32'h0);
        wait_to(s + 24);
        check("div_stop", 32'(tx), 32'h1);
        read_check("div_idle", 16'hFF01, 16'h0000);
        read_check("div_read2", 16'hFF02, 16'h0002);
        bus_write(16'hFF02, 16'd4);
`else
        // DIV address unmapped: write ignored, bits stay at CLK_DIV.
        bus_write(16'hFF02, 16'd2);
        bus_write(16'hFF00, 16'h0001);
        wait_start("const_div_start", s);
        wait_to(s + 3);
        check("const_div_start_end", 32'(tx), 32'h0);
        wait_to(s + 4);
        check("const_div_bit0", 32'(tx), 32'h1);
        wait_to(s + 8);
        check("const_div_bit1", 32'(tx), 32'h0);
        wait_idle("const_div_drain", 100);
`endif

        // Reset mid data bit 3 aborts the frame.
        bus_write(16'hFF00, 16'h0000);
        repeat (18) @(negedge clk);
        check("abort_bit3_low", 32'(tx), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx_async", 32'(tx), 32'h1);
        bus.address = 16'hFF01;
        bus.oen_n   = 1'b0;
        #1;
        check("abort_status", 32'(bus.data_in), 32'h0);
        check("abort_sel", 32'(bus.sel), 32'h1);
        bus.oen_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx == 1'b1) highs++;
        end
        check("abort_no_restart", 32'(highs), 32'd60);
        read_check("abort_idle", 16'hFF01, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_io.md
UART_IO -- requirements
Module: uart_io

Interface
REQ-001 Parameter BASE, default 16'hFF00: base address of the 3-word I/O window.
REQ-002 Parameter CLK_DIV, default 16'd434: reset value of the bit-period divisor, in clk cycles.
REQ-003 Parameter FIFO_DEPTH, default 4: TX FIFO entries, power of two.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 address  input  16  CPU bus address.
REQ-007 data_out  input  16  CPU write data.
REQ-008 wren_n  input  1  CPU write strobe, active-low.
REQ-009 oen_n  input  1  CPU read strobe, active-low.
REQ-010 data_in  output  16  read data to the CPU, combinational.
REQ-011 sel  output  1  high when address is inside the mapped window; the system read-data mux uses it.
REQ-012 tx  output  1  serial 8N1 line, idle high.

Function
REQ-013 Register map:
- BASE+0 TXDATA: write-only; a write pushes data_out[7:0].
- BASE+1 STATUS: read {13'b0, overflow, full, busy}; writing bit 2 = 1 clears overflow.
- BASE+2 DIV: read/write, 16 bits.
REQ-014 sel shall be combinational and high iff address lies in the mapped range.
REQ-015 Read path:
- data_in = selected register when sel=1 and oen_n=0, in the same cycle, because the CPU samples at the edge ending the strobe cycle.
- Otherwise data_in = 16'h0000.
- Unmapped bits and the TXDATA read return 0.
REQ-016 Write detection: a write is the first cycle with wren_n=0 and sel=1 following a cycle with wren_n=1. A strobe held low for several cycles shall act exactly once.
REQ-017 If wren_n=0 and oen_n=0 together, the write is taken and data_in = 0.
REQ-018 A TXDATA push when the FIFO is full shall be dropped and shall set the sticky overflow flag. Full is evaluated before a same-cycle pop.
REQ-019 TX FSM states and transitions:
- IDLE -> START when the FIFO is non-empty; the entry is popped on that edge.
- START -> DATA (8 bits, LSB first) -> STOP -> IDLE, or STOP -> START directly when the FIFO is non-empty.
REQ-020 Each state/bit lasts exactly max(DIV,1) cycles; a frame is 10*max(DIV,1) cycles. tx is registered.
REQ-021 Latency: a push at the edge ending cycle N into an empty FIFO with the FSM in IDLE drives the start bit (tx=0) from cycle N+2.
REQ-022 busy = (state != IDLE) or FIFO non-empty; full = FIFO count == FIFO_DEPTH.
REQ-023 A DIV write takes effect at the next bit boundary; the bit in progress keeps its old length.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; count saturates at 0 and FIFO_DEPTH, never wrapping.

Reset
REQ-025 rst_n=0 shall immediately, asynchronously, set:
- tx=1, state=IDLE, FIFO empty, overflow=0;
- DIV=CLK_DIV, write-edge detector armed.
Deasserting reset mid-frame aborts the frame; no partial bits follow.
REQ-026 data_in and sel are combinational and follow address/oen_n during reset.

Configuration
REQ-027 Macro UART_IO_DIV_REG_EN:
- Defined: DIV is writable at BASE+2 and the window is BASE..BASE+2.
- Undefined: the divisor is the constant CLK_DIV, the window is BASE..BASE+1, and BASE+2 gives sel=0 with writes ignored.

Structure
REQ-028 A shared package io_pkg holds the register offsets (TXDATA, STATUS, DIV), the STATUS bit positions and the TX state enum (IDLE, START, DATA, STOP).
REQ-029 The FIFO shall be a separate sub-module io_fifo (synchronous, parameterised depth/width, push/pop/full/empty/count); uart_io instantiates it once.

Verification
REQ-030 Reset then write 16'h0055 to FF00 with CLK_DIV=4 -> tx low from cycle N+2; then bits 1,0,1,0,1,0,1,0 for 4 cycles each; stop high; busy=0 after 40 cycles.
REQ-031 Five back-to-back TXDATA writes (0x01..0x05) while busy, depth 4 -> fifth dropped; STATUS reads 16'h0007; write 16'h0004 to FF01 -> STATUS 16'h0003.
REQ-032 wren_n held low 3 cycles on FF00 -> exactly one byte queued (count=1).
REQ-033 Write 16'd2 to FF02 mid-bit with DIV=8 -> current bit lasts 8 cycles, following bits 2 cycles; read FF02 returns 16'h0002 (macro defined); undefined -> sel=0 at FF02, read 0.
REQ-034 Assert rst_n=0 during data bit 3 -> tx=1 in the same cycle, STATUS reads 0, no further start bit.
REQ-035 Read FF01 with address FE00, or with oen_n=1 -> data_in=16'h0000, sel as per map; property: a write never occurs with sel=0.
